matrix_scan_ctrl: RTL and testbench
===================================

# matrix_scan_ctrl

Scan controller for the 16×16 RGB332 LED matrix. It walks the display-side frame buffer one row at a time by driving its read address, and turns each 8-bit pixel into 3-bit PWM serial RGB data. It generates shift clock, latch, output-enable and row-select for the panel drivers, and emits a one-cycle frame-boundary pulse so the buffer swap happens between frames without tearing.

## Interface
Parameters:
- `MATRIX_SIZE`, 16, pixels per row and number of rows; `ADDR_WIDTH` = 2·log2(MATRIX_SIZE).
- `COLOR_DEPTH`, 8, RGB332 pixel width: R = [7:5], G = [4:2], B = [1:0].
- `CLK_DIV`, 2, clk cycles per shift-clock half-period; legal values ≥ 2.
- `DISPLAY_CYCLES`, 64, clk cycles `oe_n` is held low per PWM plane; legal values ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: system clock.
- `rst` input 1: synchronous active-high reset.
- `enable` input 1: level; start scanning, or keep scanning.
- `read_addr` output ADDR_WIDTH: frame-buffer address, {row[3:0], col[3:0]}.
- `pixel_data` input COLOR_DEPTH: asynchronous read data for `read_addr`, valid in the same cycle.
- `row_sel` output 4: active row index.
- `r_out`, `g_out`, `b_out` output 1 each: serial column data.
- `sclk` output 1: panel shift clock; the panel samples on the rising edge.
- `latch` output 1: panel latch strobe.
- `oe_n` output 1: panel output enable, active-low.
- `frame_done` output 1: one-cycle pulse at the end of each full frame.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- **Reset values:** state IDLE; `read_addr` = 0, `row_sel` = 0; `r_out`, `g_out`, `b_out` = 0; `sclk` = 0, `latch` = 0; `oe_n` = 1; `frame_done` = 0; `busy` = 0.
- **Counters:**
  - `row` 0..15.
  - `plane` 0..6, seven PWM planes giving 8 levels.
  - `col` 0..15.
  - Phase counter 0..CLK_DIV-1, or 0..DISPLAY_CYCLES-1 in DISPLAY.
- **Level extraction:**
  - R3 = pixel[7:5].
  - G3 = pixel[4:2].
  - B3 = {pixel[1:0], pixel[1]}, so B2 values 0, 1, 2, 3 map to 0, 2, 5, 7.
  - A bit is lit in plane k iff level > k (unsigned 3-bit compare). Level 7 is lit in all 7 planes; level 0 is never lit.
- **States:**
  - IDLE: `oe_n` = 1. When `enable` = 1, go to SHIFT with row = plane = col = 0.
  - SHIFT: for each col, `sclk` = 0 for CLK_DIV cycles, then 1 for CLK_DIV cycles.
    - `read_addr` = {row, col} throughout the column.
    - RGB bits are registered at the end of low-phase cycle 0, so they are stable ≥ 1 cycle before the rising edge.
    - After col 15's high phase, go to LATCH with `sclk` = 0.
  - LATCH: `oe_n` = 1 and `latch` = 1 for CLK_DIV cycles.
    - `row_sel` loads `row` on the first LATCH cycle (a change is visible only when plane = 0).
    - Then go to DISPLAY.
  - DISPLAY: `oe_n` = 0 for DISPLAY_CYCLES, then `oe_n` returns to 1.
    - If plane < 6: plane++, go to SHIFT.
    - Otherwise plane = 0 and row++.
    - If row wraps from 15 to 0: pulse `frame_done` on the DISPLAY→next transition cycle. Then go to SHIFT if `enable` = 1, else IDLE.
- **`enable` deasserted mid-frame:** the current frame completes; the controller stops only at the frame boundary.
- **`rst` asserted in any state:** all outputs return to reset values on the next edge, and the partial frame is discarded.
- **`pixel_data` changes mid-frame:** allowed. Each column uses the value sampled for that column; no tearing protection exists inside a frame.

## Timing
- Per column: 2·CLK_DIV cycles.
- Per plane: 32·CLK_DIV + CLK_DIV + DISPLAY_CYCLES cycles (130 at defaults).
- Per row: 7 planes (910 cycles at defaults).
- Per frame: 16 rows (14 560 cycles at defaults).
- First rising edge of `sclk`: CLK_DIV+1 cycles after the cycle where `enable` is sampled high in IDLE.
- `latch` and `oe_n` = 0 are never high/low in the same cycle, and `sclk` is 0 whenever `latch` = 1.
- `frame_done` is followed, in the next cycle, by SHIFT of row 0, plane 0, or by IDLE.

## Structure
- Shared package `led_matrix_pkg` holds:
  - the `scan_state_t` enum (IDLE, SHIFT, LATCH, DISPLAY);
  - the RGB332 field constants;
  - the `level3(pixel, channel)` expansion function.
- One sub-module, `pwm_plane_cmp`: registered 3-channel compare of the expanded levels against `plane`, producing `r_out`, `g_out` and `b_out`.
- `MATRIX_SIZE` and `ADDR_WIDTH` come from the existing defines.

## Test plan
- Reset held mid-SHIFT → next cycle: `oe_n` = 1, `sclk` = 0, `latch` = 0, `read_addr` = 0x00, `busy` = 0, `frame_done` = 0.
- All pixels 0xFF, `enable` = 1 → every plane of every row shifts 16 ones on all three channels, with exactly 16 `sclk` rising edges between consecutive `latch` pulses.
- Pixel 0x20 at addr 0x00, all others 0 → row 0, col 0: `r_out` = 1 only in plane 0; `g_out` = `b_out` = 0 in all planes.
- Pixel 0x01 (B2 = 1 → level 2) at addr 0x35 → row 3, col 5: `b_out` = 1 in planes 0–1, 0 in planes 2–6.
- `enable` pulsed once at defaults → `frame_done` is high for one cycle 14 560 cycles after `busy` rises, then the state is IDLE with `oe_n` = 1.
- `enable` dropped during row 5 → the scan continues through row 15, `frame_done` pulses, then IDLE; `row_sel` sequence is 0..15 with no skipped or repeated row.

Source files
------------

// File: rtl/led_matrix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_pkg
// Description : Shared types and helpers for the 16x16 RGB332 LED matrix.
//               Holds the scan FSM state type, the matrix geometry
//               constants, the RGB332 field positions and the 3-bit level
//               expansion used by the PWM plane comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package led_matrix_pkg;

    // Matrix geometry
    localparam int c_MATRIX_SIZE = 16;
    localparam int c_ADDR_WIDTH  = 2 * $clog2(c_MATRIX_SIZE);

    // Pixel format (RGB332)
    localparam int c_COLOR_DEPTH = 8;
    localparam int c_R_HI        = 7;
    localparam int c_R_LO        = 5;
    localparam int c_G_HI        = 4;
    localparam int c_G_LO        = 2;
    localparam int c_B_HI        = 1;
    localparam int c_B_LO        = 0;

    // PWM: seven binary-weighted-free planes give eight brightness levels
    localparam int c_LEVEL_W     = 3;
    localparam int c_NUM_PLANES  = 7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        LATCH   = 2'd2,
        DISPLAY = 2'd3
    } scan_state_t;

    typedef enum logic [1:0] {
        CH_R = 2'd0,
        CH_G = 2'd1,
        CH_B = 2'd2
    } channel_t;

    // Expand one colour channel of an RGB332 pixel to a 3-bit level.
    // Blue has only two bits; repeating its MSB spreads 0..3 onto 0,2,5,7
    // so full blue reaches the same brightness as full red/green.
    function automatic logic [c_LEVEL_W-1:0] level3(
        input logic [c_COLOR_DEPTH-1:0] pixel,
        input channel_t                 channel
    );
        logic [c_LEVEL_W-1:0] lvl;
        case (channel)
            CH_R:    lvl = pixel[c_R_HI:c_R_LO];
            CH_G:    lvl = pixel[c_G_HI:c_G_LO];
            default: lvl = {pixel[c_B_HI:c_B_LO], pixel[c_B_HI]};
        endcase
        return lvl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_plane_cmp.sv
`default_nettype none
// ============================================================================
// Module      : pwm_plane_cmp
// Description : Registered 3-channel PWM plane compare. On i_load the pixel
//               is expanded to three 3-bit levels and each channel bit is
//               lit when its level is strictly greater than the plane index.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               i_load           - capture new compare results
//               i_pixel          - RGB332 pixel
//               i_plane          - current PWM plane (0..6)
//               o_r, o_g, o_b    - registered serial colour bits
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_plane_cmp
    import led_matrix_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_load,
    input  logic [c_COLOR_DEPTH-1:0]  i_pixel,
    input  logic [c_LEVEL_W-1:0]      i_plane,
    output logic                      o_r,
    output logic                      o_g,
    output logic                      o_b
);

    logic [c_LEVEL_W-1:0] w_lvl_r;
    logic [c_LEVEL_W-1:0] w_lvl_g;
    logic [c_LEVEL_W-1:0] w_lvl_b;

    assign w_lvl_r = level3(i_pixel, CH_R);
    assign w_lvl_g = level3(i_pixel, CH_G);
    assign w_lvl_b = level3(i_pixel, CH_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_r <= 1'b0;
            o_g <= 1'b0;
            o_b <= 1'b0;
        end else if (i_load) begin
            o_r <= (w_lvl_r > i_plane);
            o_g <= (w_lvl_g > i_plane);
            o_b <= (w_lvl_b > i_plane);
        end
    end

endmodule
`default_nettype wire

// File: rtl/matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_ctrl
// Description : Row-at-a-time scan controller for a 16x16 RGB332 LED
//               matrix. Reads the frame buffer column by column, shifts
//               PWM-plane colour bits to the panel, latches, then enables
//               the outputs for a fixed display time per plane.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               enable            - start / keep scanning (level)
//               read_addr         - frame-buffer address {row, col}
//               pixel_data        - asynchronous read data for read_addr
//               row_sel           - row currently driven on the panel
//               r_out/g_out/b_out - serial column data
//               sclk, latch, oe_n - panel shift clock, latch, output enable
//               frame_done        - one-cycle pulse at end of each frame
//               busy              - high whenever not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int MATRIX_SIZE    = c_MATRIX_SIZE,
    parameter int ADDR_WIDTH     = 2 * $clog2(MATRIX_SIZE),
    parameter int COLOR_DEPTH    = c_COLOR_DEPTH,
    parameter int CLK_DIV        = 2,
    parameter int DISPLAY_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic [ADDR_WIDTH-1:0]   read_addr,
    input  logic [COLOR_DEPTH-1:0]  pixel_data,
    output logic [ADDR_WIDTH/2-1:0] row_sel,
    output logic                    r_out,
    output logic                    g_out,
    output logic                    b_out,
    output logic                    sclk,
    output logic                    latch,
    output logic                    oe_n,
    output logic                    frame_done,
    output logic                    busy
);

    localparam int c_COORD_W = ADDR_WIDTH / 2;
    // One phase counter serves both the shift half-periods and display time
    localparam int c_PH_MAX  = (CLK_DIV > DISPLAY_CYCLES) ? CLK_DIV : DISPLAY_CYCLES;
    localparam int c_PH_W    = $clog2(c_PH_MAX);

    localparam logic [c_PH_W-1:0]    c_DIV_LAST   = c_PH_W'(CLK_DIV - 1);
    localparam logic [c_PH_W-1:0]    c_DISP_LAST  = c_PH_W'(DISPLAY_CYCLES - 1);
    localparam logic [c_COORD_W-1:0] c_COORD_LAST = c_COORD_W'(MATRIX_SIZE - 1);
    localparam logic [c_LEVEL_W-1:0] c_PLANE_LAST = c_LEVEL_W'(c_NUM_PLANES - 1);

    scan_state_t            r_state,  w_state_nxt;
    logic [c_PH_W-1:0]      r_phase,  w_phase_nxt;
    logic                   r_half,   w_half_nxt;   // 0: sclk low, 1: sclk high
    logic [c_COORD_W-1:0]   r_col,    w_col_nxt;
    logic [c_COORD_W-1:0]   r_row,    w_row_nxt;
    logic [c_LEVEL_W-1:0]   r_plane,  w_plane_nxt;
    logic [c_COORD_W-1:0]   r_row_sel;
    logic                   w_rgb_load;
    logic                   w_frame_done;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_half  <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            r_plane <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_half  <= w_half_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_plane <= w_plane_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state / counter logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_half_nxt   = r_half;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_plane_nxt  = r_plane;
        w_rgb_load   = 1'b0;
        w_frame_done = 1'b0;

        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_state_nxt = SHIFT;
                    w_phase_nxt = '0;
                    w_half_nxt  = 1'b0;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                    w_plane_nxt = '0;
                end
            end

            SHIFT: begin
                // Capture colour bits after the first low cycle so they
                // settle at least one cycle ahead of the sclk rising edge.
                w_rgb_load = !r_half && (r_phase == '0);
                if (r_phase == c_DIV_LAST) begin
                    w_phase_nxt = '0;
                    if (!r_half) begin
                        w_half_nxt = 1'b1;
                    end else begin
                        w_half_nxt = 1'b0;
                        if (r_col == c_COORD_LAST) begin
                            w_col_nxt   = '0;
                            w_state_nxt = LATCH;
                        end else begin
                            w_col_nxt = r_col + 1'b1;
                        end
                    end
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            LATCH: begin
                if (r_phase == c_DIV_LAST) begin
                    w_phase_nxt = '0;
                    w_state_nxt = DISPLAY;
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            DISPLAY: begin
                if (r_phase == c_DISP_LAST) begin
                    w_phase_nxt = '0;
                    if (r_plane != c_PLANE_LAST) begin
                        w_plane_nxt = r_plane + 1'b1;
                        w_state_nxt = SHIFT;
                    end else begin
                        w_plane_nxt = '0;
                        if (r_row == c_COORD_LAST) begin
                            // Frame boundary: the only point where scanning
                            // may stop, so a buffer swap never tears.
                            w_row_nxt    = '0;
                            w_frame_done = 1'b1;
                            w_state_nxt  = enable ? SHIFT : IDLE;
                        end else begin
                            w_row_nxt   = r_row + 1'b1;
                            w_state_nxt = SHIFT;
                        end
                    end
                end else begin
                    w_phase_nxt = r_phase + 1'b1;
                end
            end

            default: w_state_nxt = IDLE;
        endcase
    end

    // Row select follows the row being latched; it only moves on plane 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_sel <= '0;
        end else if ((r_state == LATCH) && (r_phase == '0)) begin
            r_row_sel <= r_row;
        end
    end

    pwm_plane_cmp u_pwm_plane_cmp (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_rgb_load),
        .i_pixel (pixel_data),
        .i_plane (r_plane),
        .o_r     (r_out),
        .o_g     (g_out),
        .o_b     (b_out)
    );

    assign read_addr  = {r_row, r_col};
    assign row_sel    = r_row_sel;
    assign sclk       = (r_state == SHIFT) && r_half;
    assign latch      = (r_state == LATCH);
    assign oe_n       = (r_state != DISPLAY);
    assign busy       = (r_state != IDLE);
    assign frame_done = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_scan_ctrl
// Description : Self-checking bench for matrix_scan_ctrl. A frame-buffer
//               array answers read_addr; a monitor checks every shifted
//               column bit against an arithmetic RGB332 PWM model, and
//               directed sequences cover frame timing, enable drop and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_ctrl;

    localparam int CLK_DIV        = 2;
    localparam int DISPLAY_CYCLES = 64;
    localparam int PLANE_CYCLES   = 32 * CLK_DIV + CLK_DIV + DISPLAY_CYCLES;
    localparam int FRAME_CYCLES   = 16 * 7 * PLANE_CYCLES;
    localparam int RISES_PER_FRAME = 16 * 7 * 16;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] read_addr;
    logic [7:0] pixel_data;
    logic [3:0] row_sel;
    logic       r_out, g_out, b_out;
    logic       sclk, latch, oe_n, frame_done, busy;

    logic [7:0] mem [256];
    logic [2:0] cap [16][7][16];

    int vectors;
    int miscompares;

    assign pixel_data = mem[read_addr];

    matrix_scan_ctrl #(
        .MATRIX_SIZE    (16),
        .ADDR_WIDTH     (8),
        .COLOR_DEPTH    (8),
        .CLK_DIV        (CLK_DIV),
        .DISPLAY_CYCLES (DISPLAY_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .read_addr  (read_addr),
        .pixel_data (pixel_data),
        .row_sel    (row_sel),
        .r_out      (r_out),
        .g_out      (g_out),
        .b_out      (b_out),
        .sclk       (sclk),
        .latch      (latch),
        .oe_n       (oe_n),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: level = channel value (blue spread over 0,2,5,7); lit iff level > plane
    function automatic logic [2:0] model_rgb(input logic [7:0] px, input int plane);
        int b_tab [4];
        int r, g, b;
        b_tab = '{0, 2, 5, 7};
        r = int'(px) / 32;
        g = (int'(px) / 4) % 8;
        b = b_tab[int'(px) % 4];
        return {(r > plane), (g > plane), (b > plane)};
    endfunction

    // ------------------------------------------------------------------
    // Scan monitor: every sclk rise is one column of one plane of one row
    // ------------------------------------------------------------------
    initial begin : monitor
        int         rise_idx, shifts, row, plane, col;
        logic       p_sclk, p_latch, p_oe;
        logic [2:0] p_rgb, rgb, e;
        rise_idx = 0; shifts = 0;
        p_sclk = 1'b0; p_latch = 1'b0; p_oe = 1'b1; p_rgb = 3'b000;
        forever begin
            @(negedge clk);
            rgb = {r_out, g_out, b_out};
            if (rst) begin
                rise_idx = 0;
                shifts   = 0;
            end else begin
                if (sclk && !p_sclk) begin
                    col   = rise_idx % 16;
                    plane = (rise_idx / 16) % 7;
                    row   = (rise_idx / 112) % 16;
                    check("scan_addr", 32'(read_addr), row * 16 + col);
                    e = model_rgb(mem[row * 16 + col], plane);
                    check("rgb_at_rise", 32'(rgb), 32'(e));
                    check("rgb_setup", 32'(p_rgb), 32'(e));
                    cap[row][plane][col] = rgb;
                    rise_idx++;
                    shifts++;
                end
                if (latch && !p_latch) begin
                    check("sclk_per_latch", shifts, 16);
                    shifts = 0;
                end
                if (latch) check("latch_excl", {30'd0, oe_n, sclk}, 32'd2);
                if (!oe_n && p_oe) check("row_sel", 32'(row_sel), ((rise_idx - 1) / 112) % 16);
                if (frame_done) begin
                    check("rises_per_frame", rise_idx, RISES_PER_FRAME);
                    rise_idx = 0;
                    shifts   = 0;
                end
            end
            p_sclk = sclk; p_latch = latch; p_oe = oe_n; p_rgb = rgb;
        end
    end

    // Run one frame from IDLE; pulse=1 drops enable right after it is
    // sampled, otherwise enable is dropped once row 5 is on the panel.
    task automatic run_frame(input bit pulse, output int busy_cnt, output int first_rise, output bit got);
        busy_cnt = 0; first_rise = 0; got = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= FRAME_CYCLES + 200 && !got; k++) begin
            @(negedge clk);
            if (pulse) enable = 1'b0;
            else if (row_sel == 4'd5) enable = 1'b0;
            if (busy) busy_cnt++;
            if (sclk && first_rise == 0) first_rise = k;
            if (frame_done) got = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] pixel;
        int         plane;
        logic [2:0] exp_rgb;
    } vec_t;

    vec_t tbl [13];
    int   busy_cnt, first_rise, wait_n;
    bit   got;

    initial begin
        vectors = 0; miscompares = 0;
        // {addr, pixel, plane, expected {r,g,b}}
        tbl[0]  = '{8'h00, 8'h20, 0, 3'b100};
        tbl[1]  = '{8'h00, 8'h20, 1, 3'b000};
        tbl[2]  = '{8'h00, 8'h20, 6, 3'b000};
        tbl[3]  = '{8'h35, 8'h01, 0, 3'b001};
        tbl[4]  = '{8'h35, 8'h01, 1, 3'b001};
        tbl[5]  = '{8'h35, 8'h01, 2, 3'b000};
        tbl[6]  = '{8'h35, 8'h01, 6, 3'b000};
        tbl[7]  = '{8'h9A, 8'h6D, 2, 3'b110};
        tbl[8]  = '{8'h9A, 8'h6D, 3, 3'b000};
        tbl[9]  = '{8'hF0, 8'hE3, 0, 3'b101};
        tbl[10] = '{8'hF0, 8'hE3, 6, 3'b101};
        tbl[11] = '{8'h4C, 8'h1E, 4, 3'b011};
        tbl[12] = '{8'h4C, 8'h1E, 5, 3'b010};

        rst = 1'b1; enable = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_oe_n",  32'(oe_n), 1);
        check("rst_sclk",  32'(sclk), 0);
        check("rst_latch", 32'(latch), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_fdone", 32'(frame_done), 0);
        check("rst_addr",  32'(read_addr), 0);
        check("rst_rowsel", 32'(row_sel), 0);
        check("rst_rgb",   32'({r_out, g_out, b_out}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        // Frame 1: random frame buffer with the table pixels placed in it
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 13; i++) mem[tbl[i].addr] = tbl[i].pixel;
        run_frame(1'b1, busy_cnt, first_rise, got);
        check("frame1_done_seen", 32'(got), 1);
        check("frame1_busy_cycles", busy_cnt, FRAME_CYCLES);
        check("first_sclk_rise", first_rise, CLK_DIV + 1);
        @(negedge clk);
        check("frame1_fdone_1cyc", 32'(frame_done), 0);
        check("frame1_idle", 32'(busy), 0);
        check("frame1_oe_n", 32'(oe_n), 1);
        for (int i = 0; i < 13; i++)
            check($sformatf("tbl%0d_rgb", i),
                  32'(cap[tbl[i].addr / 16][tbl[i].plane][tbl[i].addr % 16]),
                  32'(tbl[i].exp_rgb));

        // Frame 2: all white, enable held then dropped during row 5
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        run_frame(1'b0, busy_cnt, first_rise, got);
        check("frame2_done_seen", 32'(got), 1);
        check("frame2_enable_dropped", 32'(enable), 0);
        check("frame2_busy_cycles", busy_cnt, FRAME_CYCLES);
        @(negedge clk);
        check("frame2_idle", 32'(busy), 0);
        check("frame2_oe_n", 32'(oe_n), 1);

        // Reset asserted mid-SHIFT
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        enable = 1'b1;
        repeat ($urandom_range(50, 3000)) @(negedge clk);
        wait_n = 0;
        while (!(busy && oe_n && !latch) && wait_n < 300) begin
            @(negedge clk);
            wait_n++;
        end
        check("reach_shift", 32'(wait_n < 300), 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_oe_n",  32'(oe_n), 1);
        check("mid_rst_sclk",  32'(sclk), 0);
        check("mid_rst_latch", 32'(latch), 0);
        check("mid_rst_addr",  32'(read_addr), 0);
        check("mid_rst_busy",  32'(busy), 0);
        check("mid_rst_fdone", 32'(frame_done), 0);
        check("mid_rst_rowsel", 32'(row_sel), 0);
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
